// File: rtl/bounce_widget_pkg.sv
// Shared VGA constants, FSM state encoding and colour type for the bouncing widget.
package bounce_widget_pkg;
  localparam int POS_W     = 10;
  localparam int ARITH_W   = 11;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam logic [11:0] BG_COLOR = 12'h111;

  typedef enum logic [1:0] {ST_WAIT, ST_MOVE_X, ST_MOVE_Y, ST_LATCH} state_e;
  typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
endpackage

// File: rtl/bounce_widget_if.sv
// Scan position, frame timing, colour in and DAC colour out for the bouncing widget.
interface bounce_widget_if;
  import bounce_widget_pkg::*;
  logic [POS_W-1:0] pixel_x;
  logic [POS_W-1:0] pixel_y;
  logic             video_on;
  logic             frame_tick;
  logic [3:0]       red_in;
  logic [3:0]       green_in;
  logic [3:0]       blue_in;
  logic [3:0]       vga_r;
  logic [3:0]       vga_g;
  logic [3:0]       vga_b;
  logic             cycle_en;
  logic             bounce;

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick, red_in, green_in, blue_in,
    output vga_r, vga_g, vga_b, cycle_en, bounce
  );
  modport master (
    output pixel_x, pixel_y, video_on, frame_tick, red_in, green_in, blue_in,
    input  vga_r, vga_g, vga_b, cycle_en, bounce
  );
endinterface

// File: rtl/bounce_widget_axis_step.sv
// One-axis move: advance by STEP, clamp at either wall and flip direction there.
module axis_step
  import bounce_widget_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int STEP = 2
) (
  input  logic [POS_W-1:0]   pos,
  input  dir_e               dir,
  input  logic [ARITH_W-1:0] limit,
  output logic [POS_W-1:0]   pos_nxt,
  output dir_e               dir_nxt,
  output logic               reversed
);
  localparam logic [ARITH_W-1:0] SZ = ARITH_W'(SIZE);
  localparam logic [ARITH_W-1:0] ST = ARITH_W'(STEP);

  logic [ARITH_W-1:0] p;
  logic [ARITH_W-1:0] fwd;

  always_comb begin
    p        = {1'b0, pos};
    fwd      = p + ST;
    pos_nxt  = pos;
    dir_nxt  = dir;
    reversed = 1'b0;
    if (dir == DIR_INC) begin
      // far edge would pass the limit: park flush against it
      if (fwd + SZ > limit) begin
        pos_nxt  = POS_W'(limit - SZ);
        dir_nxt  = DIR_DEC;
        reversed = 1'b1;
      end else begin
        pos_nxt  = POS_W'(fwd);
      end
    end else begin
      if (p < ST) begin
        pos_nxt  = '0;
        dir_nxt  = DIR_INC;
        reversed = 1'b1;
      end else begin
        pos_nxt  = POS_W'(p - ST);
      end
    end
  end
endmodule

// File: rtl/bounce_widget.sv
// Bouncing square: moves once per frame, latches a colour snapshot, paints it over the scan.
module bounce_widget
  import bounce_widget_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int SIZE  = 32,
  parameter int STEP  = 2
) (
  input  logic            clk,
  input  logic            reset,
  bounce_widget_if.slave  bus
);
  localparam logic [ARITH_W-1:0] H_LIM = ARITH_W'(H_RES);
  localparam logic [ARITH_W-1:0] V_LIM = ARITH_W'(V_RES);
  localparam logic [ARITH_W-1:0] SZ    = ARITH_W'(SIZE);

  state_e           state, state_nxt;
  logic [POS_W-1:0] x_pos, y_pos, x_nxt, y_nxt;
  dir_e             dir_x, dir_y, dx_nxt, dy_nxt;
  logic             x_rev, y_rev, rev;
  rgb_t             snap, pix, pix_nxt;
  logic             in_x, in_y;
  logic             cycle_en, bounce;

  axis_step #(.SIZE(SIZE), .STEP(STEP)) u_step_x (
    .pos(x_pos), .dir(dir_x), .limit(H_LIM),
    .pos_nxt(x_nxt), .dir_nxt(dx_nxt), .reversed(x_rev)
  );

  axis_step #(.SIZE(SIZE), .STEP(STEP)) u_step_y (
    .pos(y_pos), .dir(dir_y), .limit(V_LIM),
    .pos_nxt(y_nxt), .dir_nxt(dy_nxt), .reversed(y_rev)
  );

  always_comb begin
    state_nxt = state;
    cycle_en  = 1'b0;
    bounce    = 1'b0;
    case (state)
      ST_WAIT:   if (bus.frame_tick) state_nxt = ST_MOVE_X;
      ST_MOVE_X: state_nxt = ST_MOVE_Y;
      ST_MOVE_Y: state_nxt = ST_LATCH;
      ST_LATCH: begin
        state_nxt = ST_WAIT;
        cycle_en  = 1'b1;
        bounce    = rev;
      end
      default:   state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  // rev accumulates both axes so a corner hit still gives a single pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_pos <= '0;
      y_pos <= '0;
      dir_x <= DIR_INC;
      dir_y <= DIR_INC;
      rev   <= 1'b0;
      snap  <= '0;
    end else begin
      case (state)
        ST_MOVE_X: begin
          x_pos <= x_nxt;
          dir_x <= dx_nxt;
          rev   <= x_rev;
        end
        ST_MOVE_Y: begin
          y_pos <= y_nxt;
          dir_y <= dy_nxt;
          rev   <= rev | y_rev;
        end
        ST_LATCH:  snap <= {bus.red_in, bus.green_in, bus.blue_in};
        default: ;
      endcase
    end
  end

  always_comb begin
    in_x = ({1'b0, bus.pixel_x} >= {1'b0, x_pos}) &&
           ({1'b0, bus.pixel_x} <  ({1'b0, x_pos} + SZ));
    in_y = ({1'b0, bus.pixel_y} >= {1'b0, y_pos}) &&
           ({1'b0, bus.pixel_y} <  ({1'b0, y_pos} + SZ));
    pix_nxt = rgb_t'(BG_COLOR);
    if (!bus.video_on)   pix_nxt = '0;
    else if (in_x && in_y) pix_nxt = snap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pix <= '0;
    else        pix <= pix_nxt;
  end

  assign bus.vga_r    = pix.r;
  assign bus.vga_g    = pix.g;
  assign bus.vga_b    = pix.b;
  assign bus.cycle_en = cycle_en;
  assign bus.bounce   = bounce;
endmodule

// File: tb/tb_bounce_widget.sv
// Scoreboard bench: stimulus queues expected frame/pixel results, negedge monitors pop and compare.
module tb_bounce_widget;
  import bounce_widget_pkg::*;

  localparam int SIZE = 32;
  localparam int STEP = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bounce_widget_if bus0 ();
  bounce_widget_if bus1 ();

  bounce_widget dut0 (.clk(clk), .reset(reset), .bus(bus0));
  bounce_widget #(.H_RES(65), .V_RES(65)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {int x; int y; int dx; int dy; int bnc; int cyc;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   pq[$];

  int checks = 0, errors = 0, cyc = 0;
  int ce0 = 0, ce1 = 0, bnc0 = 0, bnc1 = 0, acc0 = 0, acc1 = 0;
  int mx[2], my[2], mdx[2], mdy[2];
  int hres[2] = '{640, 65};
  int vres[2] = '{480, 65};
  logic px_chk = 1'b0, px_chk_d = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    px_chk_d <= px_chk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // reference movement; dir 0 = increasing, 1 = decreasing
  function automatic void mstep(input int lim, inout int p, inout int d, inout int r);
    if (d == 0) begin
      if (p + STEP + SIZE > lim) begin p = lim - SIZE; d = 1; r = 1; end
      else p = p + STEP;
    end else begin
      if (p < STEP) begin p = 0; d = 0; r = 1; end
      else p = p - STEP;
    end
  endfunction

  function automatic void push_exp(input int u);
    exp_t e;
    int r = 0;
    mstep(hres[u], mx[u], mdx[u], r);
    mstep(vres[u], my[u], mdy[u], r);
    e = '{mx[u], my[u], mdx[u], mdy[u], r, cyc};
    if (u == 0) begin q0.push_back(e); acc0++; end
    else        begin q1.push_back(e); acc1++; end
  endfunction

  task automatic latch_seen(input int u, input int x, input int y, input int dx, input int dy, input int b);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL cycle_en%0d: pulse with no accepted tick pending, got 1 expected 0", u);
      return;
    end
    if (u == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("x_pos%0d", u), x, e.x);
    chk($sformatf("y_pos%0d", u), y, e.y);
    chk($sformatf("dir_x%0d", u), dx, e.dx);
    chk($sformatf("dir_y%0d", u), dy, e.dy);
    chk($sformatf("bounce%0d", u), b, e.bnc);
    chk($sformatf("latency%0d", u), cyc - e.cyc, 3);
  endtask

  always @(negedge clk) if (reset) begin
    if (bus0.cycle_en) begin
      ce0++;
      latch_seen(0, dut0.x_pos, dut0.y_pos, int'(dut0.dir_x), int'(dut0.dir_y), int'(bus0.bounce));
    end else chk("bounce0_idle", int'(bus0.bounce), 0);
    if (bus0.bounce) bnc0++;
    if (px_chk_d) begin
      if (pq.size() == 0) begin
        checks++; errors++;
        $display("FAIL vga0: no expected pixel queued, got 0x%0h", {bus0.vga_r, bus0.vga_g, bus0.vga_b});
      end else chk("vga0", int'({bus0.vga_r, bus0.vga_g, bus0.vga_b}), pq.pop_front());
    end
  end

  always @(negedge clk) if (reset) begin
    if (bus1.cycle_en) begin
      ce1++;
      latch_seen(1, dut1.x_pos, dut1.y_pos, int'(dut1.dir_x), int'(dut1.dir_y), int'(bus1.bounce));
    end else chk("bounce1_idle", int'(bus1.bounce), 0);
    if (bus1.bounce) bnc1++;
  end

  task automatic tick(input int u);
    @(negedge clk);
    push_exp(u);
    if (u == 0) bus0.frame_tick = 1'b1;
    else        bus1.frame_tick = 1'b1;
    @(negedge clk);
    bus0.frame_tick = 1'b0;
    bus1.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pix(input int px, input int py, input bit von, input int expc);
    @(negedge clk);
    bus0.pixel_x  = 10'(px);
    bus0.pixel_y  = 10'(py);
    bus0.video_on = von;
    pq.push_back(expc);
    px_chk = 1'b1;
    @(negedge clk);
    px_chk = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, b;
    model_reset();
    bus0.pixel_x = '0; bus0.pixel_y = '0; bus0.video_on = 1'b0; bus0.frame_tick = 1'b0;
    bus0.red_in = '0; bus0.green_in = '0; bus0.blue_in = '0;
    bus1.pixel_x = '0; bus1.pixel_y = '0; bus1.video_on = 1'b0; bus1.frame_tick = 1'b0;
    bus1.red_in = '0; bus1.green_in = '0; bus1.blue_in = '0;

    #2 reset = 1'b0;
    #1;
    chk("rst_vga", int'({bus0.vga_r, bus0.vga_g, bus0.vga_b}), 0);
    chk("rst_cycle_en", int'(bus0.cycle_en), 0);
    chk("rst_bounce", int'(bus0.bounce), 0);
    chk("rst_x", dut0.x_pos, 0);
    chk("rst_y", dut0.y_pos, 0);
    chk("rst_dir_x", int'(dut0.dir_x), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // snapshot is still black after reset
    pix(100, 100, 1'b1, 'h111);
    pix(5, 5, 1'b1, 'h000);
    pix(300, 200, 1'b0, 'h000);

    bus0.red_in = 4'h3; bus0.green_in = 4'h3; bus0.blue_in = 4'h3;
    tick(0);
    chk("first_tick_x", dut0.x_pos, 2);
    chk("first_tick_y", dut0.y_pos, 2);
    repeat (3) tick(0);
    bus0.red_in = 4'h8; bus0.green_in = 4'h7; bus0.blue_in = 4'h0;
    tick(0);
    bus0.red_in = 4'hf; bus0.green_in = 4'hf; bus0.blue_in = 4'hf;
    chk("x_at_10", dut0.x_pos, 10);

    pix(10, 10, 1'b1, 'h870);
    pix(42, 10, 1'b1, 'h111);
    pix(41, 41, 1'b1, 'h870);
    pix(9, 10, 1'b1, 'h111);
    pix(10, 42, 1'b1, 'h111);
    pix(10, 10, 1'b0, 'h000);

    // second tick lands while the FSM sits in MOVE_Y and must be dropped
    @(negedge clk);
    push_exp(0);
    bus0.frame_tick = 1'b1;
    @(negedge clk) bus0.frame_tick = 1'b0;
    @(negedge clk) bus0.frame_tick = 1'b1;
    @(negedge clk) bus0.frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("x_after_double_tick", dut0.x_pos, 12);

    n = 0;
    while (mx[0] != 606 && n < 400) begin tick(0); n++; end
    chk("x_reach_606", dut0.x_pos, 606);
    // 606+32+2 = 640 is not past 640, so this frame moves without a wall hit
    tick(0);
    chk("x_606_to_608", dut0.x_pos, 608);
    chk("dir_x_still_right", int'(dut0.dir_x), 0);
    b = bnc0;
    tick(0);
    chk("x_clamped_608", dut0.x_pos, 608);
    chk("dir_x_left", int'(dut0.dir_x), 1);
    chk("bounce_at_wall", bnc0 - b, 1);
    tick(0);
    chk("x_back_606", dut0.x_pos, 606);

    // 65x65 field: 0..32 right, clamp to 33, then down to 1 on tick 33
    n = 0;
    while (!(mx[1] == 1 && mdx[1] == 1) && n < 100) begin tick(1); n++; end
    chk("dut1_ticks_to_1", n, 33);
    chk("dut1_x1", dut1.x_pos, 1);
    chk("dut1_y1", dut1.y_pos, 1);
    chk("dut1_dx_left", int'(dut1.dir_x), 1);
    chk("dut1_dy_up", int'(dut1.dir_y), 1);
    b = bnc1;
    tick(1);
    chk("corner_x0", dut1.x_pos, 0);
    chk("corner_y0", dut1.y_pos, 0);
    chk("corner_dx", int'(dut1.dir_x), 0);
    chk("corner_dy", int'(dut1.dir_y), 0);
    chk("corner_one_bounce", bnc1 - b, 1);

    // abort a frame update from MOVE_Y
    bus0.pixel_x = 10'd0; bus0.pixel_y = 10'd0; bus0.video_on = 1'b1;
    b = ce0;
    @(negedge clk) bus0.frame_tick = 1'b1;
    @(negedge clk) bus0.frame_tick = 1'b0;
    @(negedge clk);
    chk("abort_in_move_y", int'(dut0.state), int'(ST_MOVE_Y));
    chk("abort_vga_pre", int'({bus0.vga_r, bus0.vga_g, bus0.vga_b}), 'h111);
    reset = 1'b0;
    #1;
    chk("abort_vga", int'({bus0.vga_r, bus0.vga_g, bus0.vga_b}), 0);
    chk("abort_cycle_en", int'(bus0.cycle_en), 0);
    chk("abort_bounce", int'(bus0.bounce), 0);
    chk("abort_x", dut0.x_pos, 0);
    chk("abort_y", dut0.y_pos, 0);
    repeat (3) @(negedge clk);
    bus0.video_on = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    chk("abort_no_cycle_en", ce0, b);

    tick(0);
    chk("post_reset_x", dut0.x_pos, 2);
    chk("post_reset_y", dut0.y_pos, 2);

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("pix_drained", pq.size(), 0);
    chk("ce0_per_tick", ce0, acc0);
    chk("ce1_per_tick", ce1, acc1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
